// File: rtl/path_pattern_checker_pkg.sv
// path_pattern_checker_pkg: states, default pattern constants and latency clamp for the checker
package path_pattern_checker_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [7:0] DEF_POLY = 8'hB8;
  localparam logic [7:0] DEF_SEED = 8'h01;
  function automatic int clamp_lat(input int sel, input int max_lat);
    return (sel == 0) ? 1 : (sel > max_lat) ? max_lat : sel;
  endfunction
endpackage

// File: rtl/ppc_lfsr.sv
// ppc_lfsr: Fibonacci LFSR, shift-left with XOR-of-taps feedback into bit 0; zero seed forced to 1
module ppc_lfsr
  import path_pattern_checker_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] TAPS = W'(DEF_POLY),
  parameter logic [W-1:0] SEED = W'(DEF_SEED)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  output logic msb
);
  localparam logic [W-1:0] S = (SEED == '0) ? W'(1) : SEED;
  logic [W-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load ? S : shift ? {lfsr_q[W-2:0], ^(lfsr_q & TAPS)} : lfsr_q;
  always_ff @(posedge clk) lfsr_q <= !rst_n ? S : lfsr_d;
  assign msb = lfsr_q[W-1];
endmodule

// File: rtl/path_pattern_checker.sv
// path_pattern_checker: launches a serial burst, checks the looped-back bit after a set latency.
// PATH_PATTERN_CHECKER_PRBS_EN selects the LFSR pattern; otherwise an alternating 1,0,1,0 pattern.
module path_pattern_checker
  import path_pattern_checker_pkg::*;
#(
  parameter int LFSR_W = 8,
  parameter logic [LFSR_W-1:0] POLY = LFSR_W'(DEF_POLY),
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(DEF_SEED),
  parameter int MAX_LAT = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_W-1:0]             burst_len,
  input  logic [$clog2(MAX_LAT+1)-1:0] lat_sel,
  output logic                         ser_out,
  input  logic                         ser_in,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [CNT_W-1:0]             err_cnt
);
  localparam int LW = $clog2(MAX_LAT+1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [MAX_LAT-1:0] exp_q, exp_d, vld_q, vld_d;
  logic ser_q, busy_q, done_q, pass_q;
  logic accept, run, bit_now, mism;
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign run = state_q == RUN;
`ifdef PATH_PATTERN_CHECKER_PRBS_EN
  ppc_lfsr #(.W(LFSR_W), .TAPS(POLY), .SEED(SEED)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(run), .msb(bit_now)
  );
`else
  logic tog_q;
  always_ff @(posedge clk) tog_q <= (!rst_n || accept) ? 1'b1 : tog_q ^ run;
  assign bit_now = tog_q;
`endif
  // the bit launched lat edges ago sits at index lat-1 of the delay line
  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < MAX_LAT; i++)
      if (LW'(i + 1) == lat_q) mism = vld_q[i] && (ser_in != exp_q[i]);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    case (state_q)
      IDLE, DONE: if (accept) begin
        state_d = (burst_len == '0) ? DONE : RUN;
        cnt_d = burst_len;
        lat_d = LW'(clamp_lat(int'(lat_sel), MAX_LAT));
      end
      RUN: begin
        state_d = (cnt_q == ONE) ? DRAIN : RUN;
        cnt_d = (cnt_q == ONE) ? CNT_W'(lat_q) : cnt_q - ONE;
      end
      DRAIN: begin
        state_d = (cnt_q == ONE) ? DONE : DRAIN;
        cnt_d = cnt_q - ONE;
      end
      default: state_d = IDLE;
    endcase
    err_d = accept ? '0 : (mism && !(&err_q)) ? err_q + ONE : err_q;
    exp_d = (exp_q << 1) | MAX_LAT'(bit_now & run);
    vld_d = accept ? '0 : (vld_q << 1) | MAX_LAT'(run);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lat_q <= LW'(1);
      err_q <= '0;
      exp_q <= '0;
      vld_q <= '0;
      ser_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      err_q <= err_d;
      exp_q <= exp_d;
      vld_q <= vld_d;
      ser_q <= bit_now & run;
      busy_q <= (state_d == RUN) || (state_d == DRAIN);
      done_q <= state_d == DONE;
      pass_q <= (state_d == DONE) && (err_d == '0);
    end
  end
  assign ser_out = ser_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_path_pattern_checker.sv
// tb_path_pattern_checker: directed bursts through a flop loopback, scoreboarded ser_out and end-of-burst status
module tb_path_pattern_checker;
  localparam int CNT_W = 16;
  localparam int MAX_LAT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [2:0] lat_sel = '0;
  logic ser_out, ser_in, busy, done, pass;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0] chain = '0;
  logic flip = 1'b0;
  int loop_depth = 1;
  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  path_pattern_checker #(.LFSR_W(8), .POLY(8'hB8), .SEED(8'h01), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len), .lat_sel(lat_sel),
    .ser_out(ser_out), .ser_in(ser_in), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  // the DUT's own output register is the first flop of the loop; chain supplies the rest
  always @(posedge clk) chain <= {chain[2:0], ser_out};
  assign ser_in = ((loop_depth <= 1) ? ser_out : chain[2'(loop_depth - 2)]) ^ flip;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_burst(input int len, input int lat_v, input int exp_lat, input int depth,
                           input int flip_at, input int restart_at, input int exp_err);
    int c;
    int busy_n;
    logic [7:0] first8;
    logic [7:0] m;
    bit b;
    loop_depth = depth;
    exp_q.delete();
    m = 8'h01;
    for (int k = 0; k < len; k++) begin
`ifdef PATH_PATTERN_CHECKER_PRBS_EN
      exp_q.push_back(m[7]);
      m = {m[6:0], ^(m & 8'hB8)};
`else
      exp_q.push_back(k % 2 == 0);
`endif
    end
    start = 1'b1;
    burst_len = CNT_W'(len);
    lat_sel = 3'(lat_v);
    @(posedge clk); #1;
    start = 1'b0;
    burst_len = '1;
    lat_sel = 3'd1;
    c = 0;
    busy_n = 0;
    first8 = '0;
    while (!done && c < len + MAX_LAT + 6) begin
      flip = (c == flip_at);
      start = (c == restart_at);
      if (c == restart_at) burst_len = CNT_W'(3);
      if (busy) busy_n++;
      if (c >= 1 && c <= len) begin
        b = exp_q.pop_front();
        check("ser_out_bit", 32'(ser_out), 32'(b));
        if (c <= 8) first8 = {first8[6:0], ser_out};
      end
      @(posedge clk); #1;
      c++;
    end
    flip = 1'b0;
    start = 1'b0;
    check("done_cycle", c, (len == 0) ? 0 : len + exp_lat);
    check("busy_cycles", busy_n, (len == 0) ? 0 : len + exp_lat);
    check("done", 32'(done), 1);
    check("busy_after", 32'(busy), 0);
    check("ser_out_idle", 32'(ser_out), 0);
    check("err_cnt", 32'(err_cnt), exp_err);
    check("pass", 32'(pass), (exp_err == 0) ? 1 : 0);
    if (len >= 8) begin
`ifdef PATH_PATTERN_CHECKER_PRBS_EN
      check("first8", 32'(first8), 32'h01);
`else
      check("first8", 32'(first8), 32'hAA);
`endif
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ser_out", 32'(ser_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(16, 3, 3, 3, -1, -1, 0);
    run_burst(16, 3, 3, 3, 8, -1, 1);
    run_burst(0, 3, 3, 3, -1, -1, 0);
    run_burst(10, 2, 2, 2, -1, 3, 0);
    run_burst(12, 7, 4, 4, -1, -1, 0);
    run_burst(8, 0, 1, 1, -1, -1, 0);
    run_burst(9, 2, 2, 2, 6, -1, 1);
    loop_depth = 2;
    start = 1'b1;
    burst_len = CNT_W'(16);
    lat_sel = 3'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ser_out", 32'(ser_out), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_pass", 32'(pass), 0);
    check("abort_err", 32'(err_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(8, 2, 2, 2, -1, -1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/path_pattern_checker.md
# path_pattern_checker

Serial stimulus generator and self-checker that drives the data input of a register-to-register timing path and compares the bit captured at the far end against the bit it launched. It sits directly upstream of the launch flop and downstream of the capture flop of a buffer-chain path, closing the loop. It emits a pseudo-random burst, delays the expected bits by a selectable latency, and counts mismatches. It reports pass/fail at the end of the burst.

## Interface
- LFSR_W, 8, LFSR width in bits.
- POLY, 8'hB8, feedback tap mask; feedback is the XOR of `lfsr & POLY`.
- SEED, 8'h01, value loaded into the LFSR at reset and at every accepted start; 0 is illegal and is replaced by 1.
- MAX_LAT, 4, maximum loopback latency in cycles (≥1).
- CNT_W, 16, width of the burst-length and error counters.
- clk, in, 1, sole clock; all logic is rising-edge.
- rst_n, in, 1, synchronous, active-low reset.
- start, in, 1, request to begin a burst; acted on only in IDLE or DONE.
- burst_len, in, CNT_W, number of bits to launch; sampled on the accepted start.
- lat_sel, in, $clog2(MAX_LAT+1), expected loopback latency; sampled on start, 0→1, >MAX_LAT→MAX_LAT.
- ser_out, out, 1, launched bit, fed to the path's launch flop D.
- ser_in, in, 1, captured bit returned from the path's capture flop Q.
- busy, out, 1, high in RUN and DRAIN.
- done, out, 1, high in DONE; held until the next accepted start.
- pass, out, 1, valid while done is high; 1 iff err_cnt==0.
- err_cnt, out, CNT_W, mismatch count; saturates at all-ones.

## Operation
- Reset: state IDLE, lfsr=SEED, ser_out=0, busy=0, done=0, pass=0, err_cnt=0, delay line cleared.
- IDLE/DONE + start: load lfsr=SEED, bits_left=burst_len, lat=clamped lat_sel, err_cnt=0, done=0.
  - burst_len≠0 → RUN.
  - burst_len==0 → DONE next cycle with pass=1.
- RUN: each cycle ser_out=lfsr[LFSR_W-1], lfsr shifts left with the feedback into bit 0, and the expected bit plus a valid flag are pushed into a MAX_LAT-deep delay line. bits_left decrements. After the last bit → DRAIN.
- DRAIN: ser_out=0 and no pushes (valid=0 shifted in); stays for exactly lat cycles → DONE.
- Compare: every cycle the delay line tap at depth lat is checked. If its valid flag is set and ser_in≠expected, err_cnt increments, saturating.
- start in RUN/DRAIN is ignored; burst_len and lat_sel are ignored except on an accepted start.
- rst_n low mid-burst aborts immediately to reset values; no done is produced.
- ser_out=0 in IDLE, DRAIN, and DONE.

## Timing
- An accepted start on edge N puts the first bit on ser_out after edge N+1 (1-cycle start latency).
- Bit k is present on ser_out during cycle N+1+k. It is compared against ser_in sampled at the edge ending cycle N+1+k+lat-1, i.e. lat edges after launch.
- busy is high for burst_len+lat cycles. done rises the cycle after DRAIN ends.
- The final compare and the DONE transition share an edge; pass reflects the updated err_cnt.
- An error on the last bit and a saturated counter coincide → counter stays at all-ones.

## Configuration
- PATH_PATTERN_CHECKER_PRBS_EN defined: LFSR pattern as above.
- Undefined: LFSR logic is removed. ser_out alternates 1,0,1,0… starting with 1 on every burst; compare and counting are unchanged.

## Structure
- Package path_pattern_checker_pkg holds:
  - the state enum IDLE/RUN/DRAIN/DONE;
  - default POLY and SEED constants;
  - a clamp function for lat_sel.
- One sub-module, ppc_lfsr: width, tap mask, and seed as parameters; load/shift enables; serial msb output.

## Test plan
- Reset check: hold rst_n low 2 cycles → ser_out=0, busy=0, done=0, pass=0, err_cnt=0.
- Loopback through a 3-flop delay, lat_sel=3, burst_len=16, PRBS_EN:
  - first 8 ser_out bits are 0,0,0,0,0,0,0,1;
  - busy is high for 19 cycles, then done=1, pass=1, err_cnt=0.
- Same setup with ser_in inverted for one valid compare cycle → err_cnt=1, pass=0.
- burst_len=0 → busy never rises; done=1 and pass=1 one cycle after start.
- start pulsed mid-RUN with a different burst_len → ignored, and the burst length is unchanged.
  - rst_n low mid-RUN → all outputs return to reset values next cycle.
- lat_sel=7 with MAX_LAT=4 and a 4-flop loopback → treated as 4; err_cnt=0.
